// File: rtl/walk_req_arbiter.sv
// rtl/walk_req_arbiter.sv - crosswalk request latch with per-channel aging and round-robin grant
module walk_req_arbiter #(
    parameter int N_CH     = 4,
    parameter int MAX_WAIT = 200,
    parameter int AGE_W    = 8
) (
    input  logic                    clk,
    input  logic                    Reset_n,
    input  logic                    tick,
    input  logic [N_CH-1:0]         Sync_WalkReq,
    input  logic [N_CH-1:0]         WalkReg_Clear,
    input  logic                    Serve_Ack,
    output logic [N_CH-1:0]         WalkReq,
    output logic                    Grant_Valid,
    output logic [$clog2(N_CH)-1:0] Grant_Ch,
    output logic                    Urgent
);
    localparam int CW = $clog2(N_CH);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t           state;
    logic [N_CH-1:0]  req_prev;
    logic [N_CH-1:0]  edge_det;
    logic [N_CH-1:0]  set_req;
    logic [N_CH-1:0]  clr_req;
    logic [N_CH-1:0]  pend_nxt;
    logic [N_CH-1:0]  urg_now;
    logic [N_CH-1:0]  urg_nxt;
    logic [N_CH-1:0]  cand;
    logic [AGE_W-1:0] age     [N_CH];
    logic [AGE_W-1:0] age_nxt [N_CH];
    logic [CW-1:0]    rr_ptr;
    logic [CW-1:0]    pick;
    logic [CW:0]      sum;

    assign edge_det = Sync_WalkReq & ~req_prev;

    // A fresh edge re-arms a channel even when it is being cleared in the same cycle.
    always_comb begin
        clr_req  = '0;
        set_req  = '0;
        pend_nxt = '0;
        urg_now  = '0;
        urg_nxt  = '0;
        for (int i = 0; i < N_CH; i++) begin
            age_nxt[i] = age[i];
            clr_req[i] = WalkReg_Clear[i] | (Serve_Ack & Grant_Valid & (Grant_Ch == CW'(i)));
            set_req[i] = edge_det[i] & (~WalkReq[i] | clr_req[i]);
            urg_now[i] = WalkReq[i] & (age[i] == AGE_MAX);
            if (set_req[i]) begin
                pend_nxt[i] = 1'b1;
                age_nxt[i]  = '0;
            end else if (clr_req[i]) begin
                pend_nxt[i] = 1'b0;
                age_nxt[i]  = '0;
            end else begin
                pend_nxt[i] = WalkReq[i];
                if (WalkReq[i] && tick && (age[i] != AGE_MAX))
                    age_nxt[i] = age[i] + AGE_W'(1);
            end
            urg_nxt[i] = pend_nxt[i] & (age_nxt[i] == AGE_MAX);
        end
    end

    // Descending scan so the channel closest to rr_ptr is the last one written.
    always_comb begin
        cand = (|urg_now) ? urg_now : WalkReq;
        pick = '0;
        sum  = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (CW+1)'(k);
            if (sum >= (CW+1)'(N_CH))
                sum = sum - (CW+1)'(N_CH);
            if (cand[sum[CW-1:0]])
                pick = sum[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            req_prev    <= '0;
            WalkReq     <= '0;
            Urgent      <= 1'b0;
            state       <= IDLE;
            Grant_Valid <= 1'b0;
            Grant_Ch    <= '0;
            rr_ptr      <= '0;
            for (int i = 0; i < N_CH; i++)
                age[i] <= '0;
        end else begin
            req_prev <= Sync_WalkReq;
            WalkReq  <= pend_nxt;
            Urgent   <= |urg_nxt;
            for (int i = 0; i < N_CH; i++)
                age[i] <= age_nxt[i];
            case (state)
                IDLE: begin
                    if (|WalkReq) begin
                        Grant_Ch    <= pick;
                        Grant_Valid <= 1'b1;
                        state       <= OFFER;
                    end
                end
                OFFER: begin
                    if (Serve_Ack) begin
                        rr_ptr      <= (Grant_Ch == CW'(N_CH - 1)) ? '0 : Grant_Ch + 1'b1;
                        Grant_Valid <= 1'b0;
                        state       <= IDLE;
                    end else if (WalkReg_Clear[Grant_Ch]) begin
                        Grant_Valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    Grant_Valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/walk_req_arbiter.md
WALK_REQ_ARBITER -- requirements
Module: walk_req_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of crosswalk request channels (2..16).
REQ-002 Parameter MAX_WAIT, default 200, tick count after which a pending request becomes urgent (1..2**AGE_W-1).
REQ-003 Parameter AGE_W, default 8, width of each per-channel age counter.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port tick  input  1  one-cycle timebase pulse that advances the age counters.
REQ-007 Port Sync_WalkReq  input  N_CH  per-channel button request, already synchronised to clk.
REQ-008 Port WalkReg_Clear  input  N_CH  per-channel cancel of a pending request.
REQ-009 Port Serve_Ack  input  1  controller accepts the current grant.
REQ-010 Port WalkReq  output  N_CH  registered pending flag per channel.
REQ-011 Port Grant_Valid  output  1  a grant is offered on Grant_Ch.
REQ-012 Port Grant_Ch  output  clog2(N_CH)  index of the granted channel.
REQ-013 Port Urgent  output  1  at least one pending channel has age == MAX_WAIT.

Function
REQ-014 Each channel SHALL detect a rising edge of Sync_WalkReq[i] against a registered previous value; a held-high input SHALL produce exactly one request.
REQ-015 A detected edge in cycle t SHALL set WalkReq[i] in cycle t+1; a further edge while pending SHALL change nothing, including the age.
REQ-016 WalkReq[i] SHALL clear on WalkReg_Clear[i], or on Serve_Ack while Grant_Valid=1 and Grant_Ch=i.
REQ-017 Set and clear on the same channel in the same cycle: set SHALL win, and the age SHALL restart at 0.
REQ-018 Age[i] SHALL load 0 when WalkReq[i] sets, and SHALL increment on tick while WalkReq[i]=1.
REQ-019 Age[i] SHALL saturate at MAX_WAIT and SHALL never wrap; it SHALL reset to 0 when the channel clears.
REQ-020 Urgent SHALL be the registered OR over the pending channels of (age == MAX_WAIT).
REQ-021 The grant FSM SHALL have states IDLE and OFFER.
REQ-022 IDLE: Grant_Valid=0; when any WalkReq bit is 1, the FSM SHALL load Grant_Ch and move to OFFER in the next cycle.
REQ-023 Selection SHALL be round-robin starting at the pointer rr_ptr, restricted to urgent pending channels when any exist, otherwise over all pending channels.
REQ-024 OFFER: Grant_Valid=1, and Grant_Ch SHALL stay stable until exit.
REQ-025 OFFER with Serve_Ack=1 SHALL clear the granted channel, set rr_ptr=(Grant_Ch+1) mod N_CH, and return to IDLE.
REQ-026 OFFER with WalkReg_Clear[Grant_Ch]=1 and no ack SHALL withdraw the grant and return to IDLE with rr_ptr unchanged.
REQ-027 Serve_Ack SHALL be ignored in IDLE.
REQ-028 There SHALL be at least one IDLE cycle between consecutive grants.
REQ-029 Latency: an edge in cycle t SHALL give WalkReq in cycle t+1 and Grant_Valid in cycle t+2 when the FSM is idle and no other channel is pending.
REQ-030 A newly urgent channel SHALL NOT pre-empt a grant already on offer.

Reset
REQ-031 Reset_n=0 SHALL immediately force WalkReq=0, Grant_Valid=0, Grant_Ch=0, Urgent=0, all ages=0, rr_ptr=0, FSM=IDLE, and all edge-detect registers=0.
REQ-032 An input already high when Reset_n deasserts SHALL count as one rising edge.
REQ-033 Reset asserted mid-OFFER SHALL discard the grant and all pending requests without producing an ack side effect.

Verification
REQ-034 N_CH=4; 1-cycle pulse on Sync_WalkReq[2] at cycle 10 -> WalkReq=4'b0100 at cycle 11, Grant_Valid=1 with Grant_Ch=2 at cycle 12; Serve_Ack at cycle 15 -> WalkReq=0 and Grant_Valid=0 at cycle 16.
REQ-035 Channels 0, 1 and 3 pending, ack every grant -> grant order 0, 1, 3, then a new request on 0 is granted after 3 (round-robin wrap).
REQ-036 MAX_WAIT=5; channel 1 pending for 5 ticks while channel 0 holds the grant -> Urgent=1, Grant_Ch stays 0 until ack, next grant goes to 1 even though a new request on 0 is pending.
REQ-037 Sync_WalkReq[3] held high for 50 cycles with one ack -> exactly one grant; WalkReg_Clear[3] and a new edge on 3 in the same cycle -> WalkReq[3]=1 with age 0.
REQ-038 Reset_n pulled low during OFFER with 3 channels pending -> all outputs 0 asynchronously; after release with inputs low -> no grant.
REQ-039 WalkReg_Clear[Grant_Ch] during OFFER -> Grant_Valid=0 next cycle, rr_ptr unchanged, remaining pending channels granted afterwards.
